// File: rtl/same_conv_seq_if.sv
// Control, pair-stream and result-write signals of the same-mode convolution sequencer.
// master is the sequencer side; slave is the controller/MAC side.
interface same_conv_seq_if;
   logic       start_i;
   logic [5:0] size_x_i;
   logic [5:0] size_y_i;
   logic       pair_ready_i;
   logic       pair_valid_o;
   logic [4:0] addr_x_o;
   logic [4:0] addr_y_o;
   logic       first_o;
   logic       last_o;
   logic       wr_en_o;
   logic [4:0] addr_z_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   modport master (
      input  start_i, size_x_i, size_y_i, pair_ready_i,
      output pair_valid_o, addr_x_o, addr_y_o, first_o, last_o,
             wr_en_o, addr_z_o, busy_o, done_o, err_o
   );

   modport slave (
      output start_i, size_x_i, size_y_i, pair_ready_i,
      input  pair_valid_o, addr_x_o, addr_y_o, first_o, last_o,
             wr_en_o, addr_z_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/same_conv_seq.sv
// Same-mode convolution sequencer: emits (x, y) address pairs for each output k,
// then one result write strobe, with all outputs registered.
module same_conv_seq (
   input  logic            clk,
   input  logic            rst,
   same_conv_seq_if.master bus
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, DONE} state_t;

   state_t     state;
   logic [5:0] n, m;
   logic [4:0] k, i, i_end, j;
   logic       err_flag;

   logic       pair_valid, first, last, wr_en, busy, done, err;
   logic [4:0] addr_x, addr_y, addr_z;

   logic [5:0] off_c, j_c, i_start_c, i_end_c;
   logic [4:0] y_first_c, i_next, y_next;
   logic       size_bad;

   always_comb begin
      off_c     = (m - 6'd1) >> 1;
      j_c       = {1'b0, k} + off_c;
      i_start_c = (j_c >= m - 6'd1) ? (j_c - m + 6'd1) : '0;
      i_end_c   = (j_c < n - 6'd1) ? j_c : (n - 6'd1);
      // true differences lie in 0..31, so the low five bits are exact
      y_first_c = j_c[4:0] - i_start_c[4:0];
      i_next    = i + 5'd1;
      y_next    = j - i_next;
      size_bad  = (bus.size_x_i == '0) || (bus.size_x_i > 6'd32) ||
                  (bus.size_y_i == '0) || (bus.size_y_i > 6'd32);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n          <= '0;
         m          <= '0;
         k          <= '0;
         i          <= '0;
         i_end      <= '0;
         j          <= '0;
         err_flag   <= 1'b0;
         pair_valid <= 1'b0;
         addr_x     <= '0;
         addr_y     <= '0;
         first      <= 1'b0;
         last       <= 1'b0;
         wr_en      <= 1'b0;
         addr_z     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  n    <= bus.size_x_i;
                  m    <= bus.size_y_i;
                  busy <= 1'b1;
                  if (size_bad) begin
                     err_flag <= 1'b1;
                     state    <= DONE;
                  end else begin
                     k     <= '0;
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               j          <= j_c[4:0];
               i          <= i_start_c[4:0];
               i_end      <= i_end_c[4:0];
               pair_valid <= 1'b1;
               addr_x     <= i_start_c[4:0];
               addr_y     <= y_first_c;
               first      <= 1'b1;
               last       <= (i_start_c == i_end_c);
               state      <= RUN;
            end
            RUN: begin
               if (bus.pair_ready_i) begin
                  if (last) begin
                     pair_valid <= 1'b0;
                     addr_x     <= '0;
                     addr_y     <= '0;
                     first      <= 1'b0;
                     last       <= 1'b0;
                     wr_en      <= 1'b1;
                     addr_z     <= k;
                     state      <= WRITE;
                  end else begin
                     i      <= i_next;
                     addr_x <= i_next;
                     addr_y <= y_next;
                     first  <= 1'b0;
                     last   <= (i_next == i_end);
                  end
               end
            end
            WRITE: begin
               wr_en  <= 1'b0;
               addr_z <= '0;
               if ({1'b0, k} == n - 6'd1) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  k     <= k + 5'd1;
                  state <= LOAD;
               end
            end
            DONE: begin
               // arriving from IDLE on bad sizes, the pulse is raised one cycle late
               if (done) begin
                  done  <= 1'b0;
                  err   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done     <= 1'b1;
                  err      <= err_flag;
                  err_flag <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pair_valid_o = pair_valid;
   assign bus.addr_x_o     = addr_x;
   assign bus.addr_y_o     = addr_y;
   assign bus.first_o      = first;
   assign bus.last_o       = last;
   assign bus.wr_en_o      = wr_en;
   assign bus.addr_z_o     = addr_z;
   assign bus.busy_o       = busy;
   assign bus.done_o       = done;
   assign bus.err_o        = err;
endmodule

// File: tb/tb_same_conv_seq.sv
// Bench for same_conv_seq: expected pairs come from the convolution index definition
// (all i with 0<=i<N and 0<=k+off-i<M), compared cycle by cycle.
module tb_same_conv_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   same_conv_seq_if bus();
   same_conv_seq dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int x;
      int y;
      bit first;
      bit last;
   } pair_t;

   pair_t exp_p[$];
   int    exp_z[$];
   int    exp_total;
   int    vecs = 0;
   int    errs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic build_model(input int n, input int m);
      int off;
      exp_p.delete();
      exp_z.delete();
      exp_total = 1 + 2 * n;
      off = (m - 1) / 2;
      for (int k = 0; k < n; k++) begin
         pair_t grp[$];
         int jj;
         jj = k + off;
         for (int ii = 0; ii < n; ii++)
            if (jj - ii >= 0 && jj - ii < m) grp.push_back('{ii, jj - ii, 1'b0, 1'b0});
         grp[0].first = 1'b1;
         grp[grp.size() - 1].last = 1'b1;
         exp_total += grp.size();
         foreach (grp[g]) exp_p.push_back(grp[g]);
         exp_z.push_back(k);
      end
   endtask

   // mode 0: ready held high; 1: random ready and stray starts; 2: 3-cycle stall on pair #3
   task automatic run_pass(input int n, input int m, input int mode, input int abort_k);
      int cyc, stalls, stall_left, popped;
      bit rdy, done_seen;
      build_model(n, m);
      bus.size_x_i = 6'(n);
      bus.size_y_i = 6'(m);
      bus.start_i = 1'b1;
      bus.pair_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      cyc = 0; stalls = 0; stall_left = 3; popped = 0; done_seen = 1'b0;
      while (cyc < 4000 && !done_seen) begin
         cyc++;
         chk("busy", bus.busy_o, 1);
         if (bus.pair_valid_o) begin
            chk("pair_with_wr", bus.wr_en_o, 0);
            if (exp_p.size() == 0) chk("extra_pair", bus.pair_valid_o, 0);
            else begin
               chk("addr_x", bus.addr_x_o, exp_p[0].x);
               chk("addr_y", bus.addr_y_o, exp_p[0].y);
               chk("first", bus.first_o, exp_p[0].first);
               chk("last", bus.last_o, exp_p[0].last);
            end
         end else
            chk("pair_outs_zero", {bus.addr_x_o, bus.addr_y_o, bus.first_o, bus.last_o}, 0);
         if (bus.wr_en_o) begin
            if (exp_z.size() == 0) chk("extra_wr", bus.wr_en_o, 0);
            else chk("addr_z", bus.addr_z_o, exp_z.pop_front());
         end else
            chk("addr_z_zero", bus.addr_z_o, 0);
         if (bus.done_o) begin
            chk("done_cycle", cyc, exp_total + stalls);
            chk("err_legal", bus.err_o, 0);
            chk("pairs_left", exp_p.size(), 0);
            chk("writes_left", exp_z.size(), 0);
            done_seen = 1'b1;
         end else
            chk("err_quiet", bus.err_o, 0);

         if (abort_k >= 0 && bus.pair_valid_o && (n - exp_z.size()) == abort_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_outs_zero", {bus.pair_valid_o, bus.addr_x_o, bus.addr_y_o, bus.first_o,
                bus.last_o, bus.wr_en_o, bus.addr_z_o, bus.done_o, bus.err_o}, 0);
            chk("abort_busy", bus.busy_o, 0);
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               chk("abort_no_done", bus.done_o, 0);
               chk("abort_idle_busy", bus.busy_o, 0);
            end
            return;
         end

         case (mode)
            1: rdy = ($urandom % 3) != 0;
            2: begin
               rdy = 1'b1;
               if (bus.pair_valid_o && popped == 3 && stall_left > 0) begin
                  rdy = 1'b0;
                  stall_left--;
               end
            end
            default: rdy = 1'b1;
         endcase
         if (bus.pair_valid_o) begin
            if (rdy) begin
               if (exp_p.size() != 0) void'(exp_p.pop_front());
               popped++;
            end else
               stalls++;
         end
         if (mode == 1) begin
            bus.start_i = ($urandom % 5) == 0;
            bus.size_x_i = 6'($urandom_range(0, 40));
            bus.size_y_i = 6'($urandom_range(0, 40));
         end
         bus.pair_ready_i = rdy;
         if (!done_seen) begin
            @(posedge clk); #1;
         end
      end
      if (!done_seen) chk("done_timeout", bus.done_o, 1);
      if (mode == 2) chk("stall_cycles", stalls, 3);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      chk("idle_busy_after", bus.busy_o, 0);
      chk("idle_done_after", bus.done_o, 0);
      chk("idle_valid_after", bus.pair_valid_o, 0);
   endtask

   task automatic run_bad(input int n, input int m);
      bus.size_x_i = 6'(n);
      bus.size_y_i = 6'(m);
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk("bad_valid", bus.pair_valid_o, 0);
         chk("bad_wr", bus.wr_en_o, 0);
         chk("bad_busy", bus.busy_o, (c < 3) ? 1 : 0);
         chk("bad_done", bus.done_o, (c == 2) ? 1 : 0);
         chk("bad_err", bus.err_o, (c == 2) ? 1 : 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.size_x_i = '0;
      bus.size_y_i = '0;
      bus.pair_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {bus.pair_valid_o, bus.addr_x_o, bus.addr_y_o, bus.first_o, bus.last_o,
          bus.wr_en_o, bus.addr_z_o, bus.busy_o, bus.done_o, bus.err_o}, 0);
      rst = 1'b0;

      run_pass(5, 3, 0, -1);
      run_pass(1, 1, 0, -1);
      run_pass(32, 32, 0, -1);
      run_pass(5, 3, 2, -1);
      run_bad(5, 0);
      run_bad(33, 3);

      // reset and start in the same cycle: reset wins
      bus.size_x_i = 6'd5;
      bus.size_y_i = 6'd3;
      bus.start_i = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start_i = 1'b0;
      chk("rst_start_busy", bus.busy_o, 0);
      @(posedge clk); #1;
      chk("rst_start_valid", bus.pair_valid_o, 0);

      run_pass(5, 3, 0, 2);
      run_pass(5, 3, 0, -1);

      for (int r = 0; r < 6; r++)
         run_pass($urandom_range(1, 32), $urandom_range(1, 32), 1, -1);
      run_pass(32, 1, 1, -1);
      run_pass(1, 32, 1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
